// File: rtl/pcm_fifo_pkg.sv
// Shared helpers for the PCM sample FIFO: level counter width and an
// elaboration-time sanity check on the almost-full/almost-empty thresholds.
package pcm_fifo_pkg;

  function automatic int level_width(input int abits);
    return abits + 1;
  endfunction

  // Both thresholds must be reachable by a level counter holding 0..2**abits.
  function automatic bit thresholds_ok(input int abits, input int af, input int ae);
    return (af >= 0) && (af <= (1 << abits)) && (ae >= 0) && (ae <= (1 << abits));
  endfunction

endpackage

// File: rtl/pcm_fifo_ram.sv
// Simple dual-port sample store: synchronous write, registered read with a
// read enable so the output word holds while the consumer is stalled.
module pcm_fifo_ram #(
  parameter int DBITS = 16,
  parameter int ABITS = 10
) (
  input  logic             clock,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [2**ABITS];

  // Read-before-write on a shared address returns the old word, which is what
  // the full-FIFO simultaneous read/write case relies on.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pcm_fifo.sv
// PCM sample FIFO: pointer/level/flag control around pcm_fifo_ram, with an
// optional first-word-fall-through prefetch stage in front of dout.
module pcm_fifo
  import pcm_fifo_pkg::*;
#(
  parameter int DBITS    = 16,
  parameter int ABITS    = 10,
  parameter int AF_LEVEL = 2**ABITS - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic             clock,
  input  logic             reset,
  // Handshake: a write is taken on any edge where wr_en is high and the FIFO is
  // not full (or a read is taken on the same edge); a read is taken on any edge
  // where rd_en is high and empty is low. Refused requests only set the sticky
  // overflow/underflow flags.
  input  logic             wr_en,
  input  logic [DBITS-1:0] din,
  input  logic             rd_en,
  output logic [DBITS-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ABITS:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int LW = level_width(ABITS);
  localparam logic [LW-1:0] CAP = LW'(2**ABITS);
  localparam logic [LW-1:0] AF  = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE  = LW'(AE_LEVEL);

  if (!thresholds_ok(ABITS, AF_LEVEL, AE_LEVEL)) begin : g_bad_thresholds
    $error("pcm_fifo: AF_LEVEL/AE_LEVEL outside 0..2**ABITS");
  end

  logic [ABITS-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]    ram_cnt, ram_cnt_nxt, level_nxt;
  logic             s1_valid, s1_nxt, dv_nxt, empty_nxt;
  logic             rd_acc, wr_acc, fetch, load;
  logic [DBITS-1:0] rdata;

  pcm_fifo_ram #(.DBITS(DBITS), .ABITS(ABITS)) u_ram (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (fetch),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // s1_valid marks a fetched word sitting in the RAM output register; load
  // moves it into dout. In FWFT mode this forms a two-stage stallable pipe so
  // back-to-back pops sustain one word per cycle.
  always_comb begin
    rd_acc      = rd_en && !empty;
    wr_acc      = wr_en && (!full || rd_acc);
    fetch       = rd_acc;
    load        = s1_valid;
    s1_nxt      = rd_acc;
    dv_nxt      = s1_valid;
    level_nxt   = level;
    ram_cnt_nxt = ram_cnt;

    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase

    if (FWFT != 0) begin
      load   = s1_valid && (!dout_valid || rd_acc);
      fetch  = (ram_cnt != '0) && (!s1_valid || load);
      s1_nxt = fetch || (s1_valid && !load);
      dv_nxt = load || (dout_valid && !rd_acc);
    end

    case ({wr_acc, fetch})
      2'b10:   ram_cnt_nxt = ram_cnt + LW'(1);
      2'b01:   ram_cnt_nxt = ram_cnt - LW'(1);
      default: ram_cnt_nxt = ram_cnt;
    endcase

    empty_nxt = (FWFT != 0) ? !dv_nxt : (level_nxt == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      level        <= '0;
      s1_valid     <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ABITS'(1);
      if (fetch)  rd_ptr <= rd_ptr + ABITS'(1);
      if (load)   dout   <= rdata;
      ram_cnt      <= ram_cnt_nxt;
      level        <= level_nxt;
      s1_valid     <= s1_nxt;
      dout_valid   <= dv_nxt;
      empty        <= empty_nxt;
      full         <= (level_nxt == CAP);
      almost_full  <= (level_nxt >= AF);
      almost_empty <= (level_nxt <= AE);
      // A refused request in the same cycle as clr_err keeps the flag set.
      overflow     <= (wr_en && !wr_acc) || (overflow && !clr_err);
      underflow    <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

endmodule

// File: tb/tb_pcm_fifo.sv
// Scoreboard bench for pcm_fifo: one standard-read instance and one FWFT
// instance, directed vectors with expected words queued at write time.
module tb_pcm_fifo;

  localparam int DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset;

  logic        wr0, rd0, clr0;
  logic [15:0] din0, dout0;
  logic        dv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [10:0] level0;

  logic        wr1, rd1, clr1;
  logic [15:0] din1, dout1;
  logic        dv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [10:0] level1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  pcm_fifo #(.DBITS(16), .ABITS(10), .FWFT(0)) u_std (
    .clock(clock), .reset(reset), .wr_en(wr0), .din(din0), .rd_en(rd0),
    .dout(dout0), .dout_valid(dv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0),
    .overflow(ovf0), .underflow(unf0), .clr_err(clr0)
  );

  pcm_fifo #(.DBITS(16), .ABITS(10), .FWFT(1)) u_fwft (
    .clock(clock), .reset(reset), .wr_en(wr1), .din(din1), .rd_en(rd1),
    .dout(dout1), .dout_valid(dv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1),
    .overflow(ovf1), .underflow(unf1), .clr_err(clr1)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drivers
  task automatic fill0(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr0 = 1'b1;
      din0 = 16'(base + i);
      exp_q0.push_back(16'(base + i));
      tick();
    end
    wr0 = 1'b0;
  endtask

  task automatic drain0(input int n);
    rd0 = 1'b1;
    repeat (n) tick();
    rd0 = 1'b0;
    tick();
    tick();
  endtask

  // monitors: standard mode pulses dout_valid per word; FWFT compares at pop
  always @(negedge clock) begin
    if (!reset && dv0) begin
      if (exp_q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL std_dout_unexpected: got 0x%0h expected no word", dout0);
      end else begin
        check("std_dout", {16'h0, dout0}, {16'h0, exp_q0.pop_front()});
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && rd1 && dv1) begin
      if (exp_q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fwft_dout_unexpected: got 0x%0h expected no word", dout1);
      end else begin
        check("fwft_dout", {16'h0, dout1}, {16'h0, exp_q1.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1;
    wr0 = 0; rd0 = 0; clr0 = 0; din0 = '0;
    wr1 = 0; rd1 = 0; clr1 = 0; din1 = '0;
    repeat (3) tick();
    check("rst_level0", level0, 0);
    check("rst_empty0", empty0, 1);
    check("rst_full0", full0, 0);
    check("rst_ae0", ae0, 1);
    check("rst_af0", af0, 0);
    check("rst_dout0", dout0, 0);
    check("rst_dv0", dv0, 0);
    check("rst_flags0", {ovf0, unf0}, 0);
    check("rst_dv1", dv1, 0);
    check("rst_empty1", empty1, 1);
    reset = 1'b0;
    tick();

    // fill to capacity, watching almost_full cross at 1020
    for (int i = 0; i < DEPTH; i++) begin
      wr0 = 1'b1;
      din0 = 16'(i);
      exp_q0.push_back(16'(i));
      tick();
      if (i == 1018) check("af_at_1019", af0, 0);
      if (i == 1019) begin
        check("af_at_1020", af0, 1);
        check("level_1020", level0, 1020);
      end
      if (i == 3) check("ae_at_4", ae0, 1);
      if (i == 4) check("ae_at_5", ae0, 0);
    end
    check("full_after_fill", full0, 1);
    check("level_after_fill", level0, 1024);
    din0 = 16'hBEEF;
    tick();
    wr0 = 1'b0;
    check("ovf_on_full_write", ovf0, 1);
    check("level_after_ovf", level0, 1024);

    // drain everything, then a rejected read
    rd0 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      if (i == DEPTH - 1) begin
        check("empty_after_drain", empty0, 1);
        check("level_after_drain", level0, 0);
      end
    end
    rd0 = 1'b0;
    tick();
    tick();
    check("std_queue_drained", exp_q0.size(), 0);
    check("dout_last", dout0, 16'h03FF);
    rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    check("unf_on_empty_read", unf0, 1);
    tick();
    check("dv_after_bad_read", dv0, 0);
    check("dout_held", dout0, 16'h03FF);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    check("flags_cleared", {ovf0, unf0}, 0);

    // full FIFO, simultaneous read+write across pointer wrap
    fill0(DEPTH, 0);
    rd0 = 1'b1;
    wr0 = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      din0 = 16'(DEPTH + i);
      exp_q0.push_back(16'(DEPTH + i));
      tick();
      if (i % 500 == 499) begin
        check("level_stream", level0, 1024);
        check("full_stream", full0, 1);
      end
    end
    wr0 = 1'b0;
    check("no_ovf_stream", ovf0, 0);
    drain0(DEPTH);
    check("std_queue_after_stream", exp_q0.size(), 0);

    // empty FIFO, simultaneous read+write
    rd0 = 1'b1;
    wr0 = 1'b1;
    din0 = 16'hA5A5;
    exp_q0.push_back(16'hA5A5);
    tick();
    rd0 = 1'b0;
    wr0 = 1'b0;
    check("unf_rdwr_empty", unf0, 1);
    check("level_rdwr_empty", level0, 1);
    check("empty_rdwr_empty", empty0, 0);
    drain0(1);
    check("a5a5_read", exp_q0.size(), 0);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;

    // FWFT: single word latency
    wr1 = 1'b1;
    din1 = 16'h1234;
    exp_q1.push_back(16'h1234);
    tick();
    wr1 = 1'b0;
    check("fwft_level_n", level1, 1);
    check("fwft_empty_n", empty1, 1);
    tick();
    check("fwft_dv_n1", dv1, 0);
    tick();
    check("fwft_dv_n2", dv1, 1);
    check("fwft_dout_n2", dout1, 16'h1234);
    check("fwft_empty_n2", empty1, 0);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    check("fwft_empty_pop", empty1, 1);
    check("fwft_level_pop", level1, 0);

    // FWFT: back-to-back pops once primed
    for (int i = 0; i < 6; i++) begin
      wr1 = 1'b1;
      din1 = 16'(16'h2000 + i);
      exp_q1.push_back(16'(16'h2000 + i));
      tick();
    end
    wr1 = 1'b0;
    repeat (3) tick();
    check("fwft_level_6", level1, 6);
    rd1 = 1'b1;
    repeat (6) tick();
    rd1 = 1'b0;
    check("fwft_level_b2b", level1, 0);
    check("fwft_empty_b2b", empty1, 1);
    check("fwft_no_unf_b2b", unf1, 0);
    check("fwft_queue", exp_q1.size(), 0);

    // rejected read alongside clr_err keeps underflow
    rd1 = 1'b1;
    clr1 = 1'b1;
    tick();
    rd1 = 1'b0;
    check("unf_set_wins", unf1, 1);
    tick();
    clr1 = 1'b0;
    check("unf_cleared", unf1, 0);

    // reset mid-stream at level 37 with overflow set
    fill0(DEPTH, 16'h4000);
    wr0 = 1'b1;
    din0 = 16'hDEAD;
    tick();
    wr0 = 1'b0;
    drain0(DEPTH - 37);
    check("level_37", level0, 37);
    check("ovf_before_reset", ovf0, 1);
    check("queue_37", exp_q0.size(), 37);
    rd0 = 1'b1;
    wr0 = 1'b1;
    din0 = 16'h7777;
    #2 reset = 1'b1;
    #1;
    rd0 = 1'b0;
    wr0 = 1'b0;
    exp_q0.delete();
    check("mid_rst_level", level0, 0);
    check("mid_rst_flags", {ovf0, unf0}, 0);
    check("mid_rst_empty_full", {empty0, full0}, 2'b10);
    check("mid_rst_ae_af", {ae0, af0}, 2'b10);
    check("mid_rst_dout", {dv0, dout0}, 0);
    tick();
    reset = 1'b0;
    tick();

    // clr_err with a simultaneous rejected write keeps overflow
    fill0(DEPTH, 16'h8000);
    wr0 = 1'b1;
    clr0 = 1'b1;
    din0 = 16'hDEAD;
    tick();
    wr0 = 1'b0;
    clr0 = 1'b0;
    check("ovf_set_wins", ovf0, 1);
    check("level_after_clr_ovf", level0, 1024);
    drain0(DEPTH);
    check("std_queue_final", exp_q0.size(), 0);
    check("fwft_queue_final", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
